// File: rtl/mux_stream_arbiter.sv
// Purpose : round-robin merge of CHANNELS valid/ready streams into one registered output word.
// Latency : 1 cycle from an input transfer to out_valid with that word; one word per cycle sustained.
// Backpr. : when out_valid is held without out_ready, every in_ready is low and priority is frozen.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   in_data/in_valid         CHANNELS packed input words (channel i at [i*WIDTH +: WIDTH]) and valids
//   in_ready                 one-hot (or zero) ready back to the granted channel
//   out_data/out_chan        registered word and the channel it came from
//   out_valid/out_ready      output handshake
module mux_stream_arbiter #(
    parameter int WIDTH    = 1,
    parameter int SIZE     = 2,
    parameter int CHANNELS = 2**SIZE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SIZE-1:0]           out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [SIZE-1:0]     r_ptr;
    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_data;
    logic [SIZE-1:0]     r_out_chan;

    logic                w_load_en;
    logic                w_found;
    logic [SIZE-1:0]     w_gnt_idx;
    logic [SIZE-1:0]     w_idx;
    logic                w_take;
    logic [CHANNELS-1:0] w_in_ready;

    // The output register can accept a new word when empty or draining this cycle.
    assign w_load_en = !r_out_valid || out_ready;

    // Search starts at r_ptr; SIZE-bit addition wraps naturally because CHANNELS == 2**SIZE.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_idx     = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_idx = r_ptr + SIZE'(k);
            if (!w_found && in_valid[w_idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_idx;
            end
        end
    end

    // Reset masks the grant so no transfer is reported while the state is being cleared.
    assign w_take = w_found && w_load_en && !rst;

    always_comb begin
        w_in_ready = '0;
        if (w_take) begin
            w_in_ready[w_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
        end else if (w_take) begin
            // Load (possibly replacing a word draining on this same edge).
            r_out_data  <= in_data[w_gnt_idx*WIDTH +: WIDTH];
            r_out_chan  <= w_gnt_idx;
            r_out_valid <= 1'b1;
            r_ptr       <= w_gnt_idx + SIZE'(1);
        end else if (out_ready) begin
            // Drain without refill; data and channel keep their last value.
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_stream_arbiter.sv
module tb_mux_stream_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Four-channel instance, WIDTH=8
    logic        rst4;
    logic [31:0] in_data4;
    logic [3:0]  in_valid4;
    logic [3:0]  in_ready4;
    logic [7:0]  out_data4;
    logic [1:0]  out_chan4;
    logic        out_valid4;
    logic        out_ready4;

    // Two-channel instance, WIDTH=8
    logic        rst2;
    logic [15:0] in_data2;
    logic [1:0]  in_valid2;
    logic [1:0]  in_ready2;
    logic [7:0]  out_data2;
    logic        out_chan2;
    logic        out_valid2;
    logic        out_ready2;

    mux_stream_arbiter #(.WIDTH(8), .SIZE(2), .CHANNELS(4)) dut4 (
        .clk(clk), .rst(rst4),
        .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
        .out_data(out_data4), .out_chan(out_chan4),
        .out_valid(out_valid4), .out_ready(out_ready4)
    );

    mux_stream_arbiter #(.WIDTH(8), .SIZE(1), .CHANNELS(2)) dut2 (
        .clk(clk), .rst(rst2),
        .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .out_data(out_data2), .out_chan(out_chan2),
        .out_valid(out_valid2), .out_ready(out_ready2)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state: priority pointer and contents of the one-entry output register.
    int       m4_ptr, m4_chan, m2_ptr, m2_chan;
    bit       m4_vld, m2_vld;
    bit [7:0] m4_dat, m2_dat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First valid channel scanning ptr, ptr+1, ... modulo n; -1 when none.
    function automatic int rr_pick(int ptr, int n, logic [3:0] v);
        for (int k = 0; k < n; k++) begin
            int i;
            i = (ptr + k) % n;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // One clock of the 4-channel DUT: drive, check ready, advance model, check outputs.
    task automatic step4(input logic r, input logic [3:0] v, input logic [31:0] d, input logic ordy);
        int g;
        logic [3:0] er;
        rst4 = r; in_valid4 = v; in_data4 = d; out_ready4 = ordy;
        #1;
        g  = rr_pick(m4_ptr, 4, v);
        er = '0;
        if (!r && g >= 0 && (!m4_vld || ordy)) er[g] = 1'b1;
        chk("in_ready4", in_ready4, er);
        @(posedge clk);
        if (r) begin
            m4_ptr = 0; m4_vld = 0; m4_dat = 0; m4_chan = 0;
        end else if (er != 0) begin
            m4_dat = d[g*8 +: 8]; m4_chan = g; m4_vld = 1; m4_ptr = (g + 1) % 4;
        end else if (ordy) begin
            m4_vld = 0;
        end
        #1;
        chk("out_valid4", out_valid4, m4_vld);
        chk("out_data4", out_data4, m4_dat);
        chk("out_chan4", out_chan4, m4_chan);
        chk("ptr4", dut4.r_ptr, m4_ptr);
        @(negedge clk);
    endtask

    task automatic step2(input logic r, input logic [1:0] v, input logic [15:0] d, input logic ordy);
        int g;
        logic [1:0] er;
        rst2 = r; in_valid2 = v; in_data2 = d; out_ready2 = ordy;
        #1;
        g  = rr_pick(m2_ptr, 2, {2'b00, v});
        er = '0;
        if (!r && g >= 0 && (!m2_vld || ordy)) er[g] = 1'b1;
        chk("in_ready2", in_ready2, er);
        @(posedge clk);
        if (r) begin
            m2_ptr = 0; m2_vld = 0; m2_dat = 0; m2_chan = 0;
        end else if (er != 0) begin
            m2_dat = d[g*8 +: 8]; m2_chan = g; m2_vld = 1; m2_ptr = (g + 1) % 2;
        end else if (ordy) begin
            m2_vld = 0;
        end
        #1;
        chk("out_valid2", out_valid2, m2_vld);
        chk("out_data2", out_data2, m2_dat);
        chk("out_chan2", out_chan2, m2_chan);
        chk("ptr2", dut2.r_ptr, m2_ptr);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] fair_d;
        rst4 = 1'b1; in_valid4 = '0; in_data4 = '0; out_ready4 = 1'b0;
        rst2 = 1'b1; in_valid2 = '0; in_data2 = '0; out_ready2 = 1'b0;
        m4_ptr = 0; m4_vld = 0; m4_dat = 0; m4_chan = 0;
        m2_ptr = 0; m2_vld = 0; m2_dat = 0; m2_chan = 0;
        @(negedge clk);

        // Reset held two cycles with every channel requesting
        fair_d = 32'hA3A2A1A0;
        step4(1'b1, 4'hF, fair_d, 1'b1);
        step4(1'b1, 4'hF, fair_d, 1'b1);
        chk("rst_valid", out_valid4, 1'b0);
        chk("rst_data", out_data4, 8'h00);

        // Fairness: continuous requests, one word per cycle in rotating order
        for (int k = 0; k < 8; k++) begin
            step4(1'b0, 4'hF, fair_d, 1'b1);
            chk("fair_chan", out_chan4, k % 4);
            chk("fair_data", out_data4, 8'hA0 + (k % 4));
        end

        // Priority skip: grant 1 moves ptr to 2, then 0011 wraps to 0, then 1
        step4(1'b0, 4'b0010, 32'h00001100, 1'b1);
        step4(1'b0, 4'b0011, 32'h00002211, 1'b1);
        chk("skip_chan0", out_chan4, 0);
        step4(1'b0, 4'b0011, 32'h00002211, 1'b1);
        chk("skip_chan1", out_chan4, 1);

        // Backpressure: hold channel-2 word 5C for three cycles
        step4(1'b0, 4'b0100, 32'hD35C0000, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step4(1'b0, 4'hF, 32'hD35C0000, 1'b0);
            chk("bp_data", out_data4, 8'h5C);
            chk("bp_chan", out_chan4, 2);
        end
        step4(1'b0, 4'hF, 32'hD35C0000, 1'b1);
        chk("bp_reload_chan", out_chan4, 3);

        // Drain without refill
        step4(1'b0, 4'h0, 32'h0, 1'b1);
        chk("drain_valid", out_valid4, 1'b0);
        chk("drain_data", out_data4, 8'hD3);

        // Randomized traffic with occasional reset
        for (int k = 0; k < 300; k++) begin
            step4(($urandom_range(0, 39) == 0), 4'($urandom), $urandom, 1'($urandom));
        end
        rst4 = 1'b1;

        // Two-channel: load, hold, reset mid-stream, then channel 0 wins
        step2(1'b1, 2'b11, 16'h0000, 1'b0);
        step2(1'b0, 2'b01, 16'h7788, 1'b0);
        step2(1'b0, 2'b11, 16'h7788, 1'b0);
        chk("hold2_valid", out_valid2, 1'b1);
        step2(1'b1, 2'b11, 16'h7788, 1'b0);
        chk("mrst_valid", out_valid2, 1'b0);
        chk("mrst_data", out_data2, 8'h00);
        step2(1'b0, 2'b11, 16'h6655, 1'b1);
        chk("mrst_chan", out_chan2, 0);
        chk("mrst_word", out_data2, 8'h55);
        for (int k = 0; k < 150; k++) begin
            step2(($urandom_range(0, 29) == 0), 2'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux_stream_arbiter.md
# mux_stream_arbiter

Round-robin arbiter that merges CHANNELS valid/ready input streams into one registered output stream. It generates the channel select internally and performs the data selection that a Mux of the same WIDTH/SIZE would do. It sits directly upstream of any single-consumer stage fed by a shared Mux, and adds a one-entry output register and fair arbitration.

## Interface
- WIDTH, 1, data width per channel
- SIZE, 2, select width
- CHANNELS, 2**SIZE, number of input channels

- clk  input  1  clock. One clock; reset is synchronous and active-high.
- rst  input  1  reset, sampled on the rising edge of clk.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel valid
- in_ready  output  CHANNELS  per-channel ready; at most one bit set
- out_data  output  WIDTH  registered selected word
- out_chan  output  SIZE  index of the channel that produced out_data
- out_valid  output  1  output register holds a word
- out_ready  input  1  downstream accepts the word

## Operation
- State:
  - ptr [SIZE-1:0]: highest-priority channel.
  - Output register: out_valid, out_data, out_chan.
- load_en = !out_valid | out_ready.
- Grant is combinational: the first i with in_valid[i]=1, searching ptr, ptr+1, … CHANNELS-1, 0, … ptr-1 (mod CHANNELS). When no channel is valid, there is no grant.
- in_ready[i] = load_en & grant[i]. When rst=1, in_ready is forced to all zeros.
- Input transfer on channel g happens when in_valid[g] & in_ready[g]. On the next edge:
  - out_data <= in_data[g*WIDTH +: WIDTH]
  - out_chan <= g
  - out_valid <= 1
  - ptr <= (g+1) mod CHANNELS, wrapping from CHANNELS-1 to 0.
- Output transfer happens when out_valid & out_ready. If there is no simultaneous input transfer, out_valid <= 0. out_data and out_chan keep their last value.
- Simultaneous drain and load: the new word replaces the old in the same edge and out_valid stays 1. Sustained throughput is one word per cycle.
- While out_valid=1 and out_ready=0:
  - out_data, out_chan and out_valid hold stable.
  - in_ready is all zeros.
  - ptr does not change.
- ptr changes only on an input transfer. Idle cycles do not rotate priority.
- Reset value of every output:
  - out_valid=0
  - out_data=0
  - out_chan=0
  - in_ready=0 during rst
  - ptr=0 internally
- Reset mid-operation discards a held output word and performs no transfer in that cycle.
- SIZE=1 (2 channels) must be supported. Behaviour for SIZE=0 is undefined.

## Timing
- Latency: 1 cycle from an input transfer to out_valid=1 with that word.
- Combinational paths:
  - in_ready depends on in_valid, ptr, out_valid and out_ready.
  - There is no combinational path from in_data or in_valid to out_data, out_chan or out_valid.
- Upstream may hold in_valid high without in_ready. Data must remain stable until the transfer; the block does not check this.
- Downstream may assert out_ready at any time; out_ready with out_valid=0 has no effect.
- First possible grant is the first cycle after rst deasserts. It goes to the lowest valid channel, because ptr=0.

## Test plan
- Reset: hold rst for 2 cycles with all in_valid=1. Required: in_ready=0000, out_valid=0, out_data=0, out_chan=0. After release, the first transfer is channel 0.
- Fairness, WIDTH=8, SIZE=2: in_valid=1111 continuously, out_ready=1, in_data[i]=8'hA0+i. Required: out_chan sequence 0,1,2,3,0,1…, out_data A0,A1,A2,A3,A0, one word per cycle.
- Priority skip: ptr=2 after a grant to 1, in_valid=0011. Required: grant channel 0 next, then ptr=1. Next grant from 0011 is channel 1.
- Backpressure: out_valid=1 with out_chan=2 and out_data=8'h5C, then out_ready=0 for 3 cycles with in_valid=1111. Required: outputs stable, in_ready=0000, ptr unchanged. When out_ready=1, the same-edge load takes channel 3.
- Drain without refill: out_valid=1, out_ready=1, in_valid=0000. Required: out_valid=0 next cycle, out_data and out_chan unchanged, ptr unchanged.
- Mid-stream reset with SIZE=1: out_valid=1 holding a word, assert rst for 1 cycle. Required: out_valid=0, out_data=0, ptr=0. After release with in_valid=11, channel 0 wins.
